// File: rtl/run_detector_pkg.sv
// rtl/run_detector_pkg.sv - shared state/mode codes and helpers for run_detector
// Contents: state_e (IDLE/RUN0/RUN1), mode_e (EITHER/ZEROS/ONES/OFF),
//           RUN_W (run register width), mode_allows() polarity filter.
package run_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN0 = 2'b01,
    ST_RUN1 = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_EITHER = 2'b00,
    MODE_ZEROS  = 2'b01,
    MODE_ONES   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  // Wide enough for run lengths up to 16.
  localparam int RUN_W = 5;

  // True when the polarity filter lets a completed run in state st raise z.
  function automatic logic mode_allows(input logic [1:0] mode, input state_e st);
    logic ok;
    case (mode_e'(mode))
      MODE_EITHER: ok = (st == ST_RUN0) || (st == ST_RUN1);
      MODE_ZEROS:  ok = (st == ST_RUN0);
      MODE_ONES:   ok = (st == ST_RUN1);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// rtl/run_detector_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, reset (async active-low), clr (sync clear, wins over inc),
//        inc (count enable), q (count, sticks at all-ones).
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - serial equal-bit run detector with polarity filter and match counter
// Ports: clk, reset (async active-low), en (sample enable), w (serial bit),
//        mode (00 either, 01 zeros, 10 ones, 11 off), nonoverlap, clr (clears count),
//        z (registered match), state (IDLE/RUN0/RUN1), run (saturating length),
//        match_count (saturating).
module run_detector
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             nonoverlap,
  input  logic             clr,
  output logic             z,
  output logic [1:0]       state,
  output logic [RUN_W-1:0] run,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             z_q, z_d;
  logic             inc;
  state_e           w_state;

  assign w_state = w ? ST_RUN1 : ST_RUN0;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (en) begin
      // IDLE never equals a RUN code, so the first sample lands here too.
      if (state_q != w_state) begin
        state_d = w_state;
        run_d   = RUN_W'(1);
      end else if (run_q == RUN_MAX) begin
        if (nonoverlap) begin
          run_d = RUN_W'(1);
        end
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end
    // z depends only on the next registered state, so w never reaches z combinationally.
    z_d = (run_d == RUN_MAX) && mode_allows(mode, state_d);
  end

  // With nonoverlap a completed run restarts at 1, and a fresh run can only
  // reach RUN_MAX from below, so an enabled edge ending with z=1 is always a new match.
  assign inc = en && z_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      z_q     <= z_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .inc  (inc),
    .q    (match_count)
  );

  assign z     = z_q;
  assign state = state_q;
  assign run   = run_q;

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - self-checking scoreboard bench for run_detector
module tb_run_detector;

  localparam int RL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       w;
  logic [1:0] mode;
  logic       nonoverlap;
  logic       clr;

  logic       z_a, z_b;
  logic [1:0] state_a, state_b;
  logic [4:0] run_a, run_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  typedef struct {
    string tag;
    int    st;
    int    run;
    int    z;
    int    ca;
    int    cb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int m_st, m_run, m_z, m_ca, m_cb;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(RL)) dut_a (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode),
    .nonoverlap(nonoverlap), .clr(clr), .z(z_a), .state(state_a),
    .run(run_a), .match_count(cnt_a)
  );

  run_detector #(.RUN_LEN(RL), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode),
    .nonoverlap(nonoverlap), .clr(clr), .z(z_b), .state(state_b),
    .run(run_b), .match_count(cnt_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int allowed(input int md, input int st);
    if (md == 0) return 1;
    if (md == 1) return (st == 1) ? 1 : 0;
    if (md == 2) return (st == 2) ? 1 : 0;
    return 0;
  endfunction

  task automatic check_all(input exp_t e);
    chk({e.tag, ".state"}, int'(state_a), e.st);
    chk({e.tag, ".run"},   int'(run_a),   e.run);
    chk({e.tag, ".z"},     int'(z_a),     e.z);
    chk({e.tag, ".cnt8"},  int'(cnt_a),   e.ca);
    chk({e.tag, ".cnt2"},  int'(cnt_b),   e.cb);
    chk({e.tag, ".z2"},    int'(z_b),     e.z);
  endtask

  // Drive one sample, push the model's prediction, and compare after the edge.
  task automatic step(input logic en_v, input logic w_v, input string tag);
    exp_t e;
    int   ws;
    en = en_v;
    w  = w_v;
    if (en_v) begin
      ws = w_v ? 2 : 1;
      if (m_st != ws) begin
        m_st  = ws;
        m_run = 1;
      end else if (m_run < RL) begin
        m_run = m_run + 1;
      end else if (nonoverlap) begin
        m_run = 1;
      end
    end
    m_z = (m_run == RL) ? allowed(int'(mode), m_st) : 0;
    if (clr) begin
      m_ca = 0;
      m_cb = 0;
    end else if (en_v && m_z == 1) begin
      if (m_ca < 255) m_ca++;
      if (m_cb < 3)   m_cb++;
    end
    e.tag = tag; e.st = m_st; e.run = m_run; e.z = m_z; e.ca = m_ca; e.cb = m_cb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_all(e);
  endtask

  // Asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    exp_t e;
    reset = 1'b0;
    m_st = 0; m_run = 0; m_z = 0; m_ca = 0; m_cb = 0;
    e.tag = tag; e.st = 0; e.run = 0; e.z = 0; e.ca = 0; e.cb = 0;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check_all(e);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1'b0; w = 1'b0; mode = 2'b00; nonoverlap = 1'b0; clr = 1'b0;
    reset = 1'b0;
    #1;
    do_reset("rst0");

    // Overlapping ones: z=0,0,0,1,1 and two matches.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $sformatf("ovl%0d", i));
    chk("ovl.cnt_fixed", int'(cnt_a), 2);
    chk("ovl.run_fixed", int'(run_a), 4);

    // Non-overlapping zeros: matches after samples 4 and 8.
    do_reset("rst1");
    nonoverlap = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $sformatf("nov%0d", i));
    chk("nov.cnt_fixed", int'(cnt_a), 2);
    nonoverlap = 1'b0;

    // Zeros-only filter ignores a run of ones.
    do_reset("rst2");
    mode = 2'b01;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $sformatf("zo1_%0d", i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $sformatf("zo0_%0d", i));
    chk("zo.cnt_fixed", int'(cnt_a), 1);
    chk("zo.z_fixed", int'(z_a), 1);

    // Mode switch mid-run: state and run kept, z follows the new filter.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $sformatf("ms1_%0d", i));
    mode = 2'b10;
    step(1'b1, 1'b1, "ms_ones");
    mode = 2'b11;
    step(1'b1, 1'b1, "ms_off");
    mode = 2'b00;

    // Reset in the middle of a run discards it.
    do_reset("rst3");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $sformatf("mr%0d", i));
    do_reset("rst_mid");
    step(1'b1, 1'b1, "mr_after");
    chk("mr.run_fixed", int'(run_a), 1);

    // Five overlapping matches saturate the 2-bit counter; clr wins over a match.
    do_reset("rst4");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, $sformatf("sat%0d", i));
    chk("sat.cnt2_fixed", int'(cnt_b), 3);
    chk("sat.cnt8_fixed", int'(cnt_a), 5);
    clr = 1'b1;
    step(1'b1, 1'b1, "clr_match");
    clr = 1'b0;
    step(1'b1, 1'b1, "after_clr");

    // Enable toggling: only enabled edges advance the run.
    do_reset("rst5");
    for (int i = 0; i < 10; i++) step((i % 2) == 0, 1'b1, $sformatf("en%0d", i));

    // Alternating bits never complete a run.
    do_reset("rst6");
    for (int i = 0; i < 6; i++) step(1'b1, logic'(i % 2), $sformatf("alt%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
